// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the alu_issue stage.
// ALU control codes, MIPS opcode/funct encodings, the S1 decoded record,
// and small immediate-extension helpers.
// Build option: ALU_ISSUE_OVF_TRAP_EN enables the arithmetic overflow trap.
package alu_issue_pkg;

    // ALU control codes understood by the downstream combinational ALU
    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUBU = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Overflow trap enable; when clear, ovf_chk never reaches S1
`ifdef ALU_ISSUE_OVF_TRAP_EN
    localparam logic OVF_TRAP_EN = 1'b1;
`else
    localparam logic OVF_TRAP_EN = 1'b0;
`endif

    // Decoded instruction held in S1
    typedef struct packed {
        logic [3:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wr_addr;
        logic        wr_en;
        logic        ovf_chk;
        logic        illegal;
    } s1_rec_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// alu_issue_dec: purely combinational decoder from instruction word and
// register operands to the S1 record (aluc, operands, destination, flags).
// Build option: ALU_ISSUE_OVF_TRAP_EN (via alu_issue_pkg::OVF_TRAP_EN).
module alu_issue_dec
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output s1_rec_t     rec_o
);

    logic [5:0]  op_s;
    logic [5:0]  funct_s;
    logic [4:0]  rt_idx_s;
    logic [4:0]  rd_idx_s;
    logic [4:0]  shamt_s;
    logic [15:0] imm_s;
    logic [4:0]  unused_rs_idx_s;

    logic [3:0]  aluc_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [4:0]  dest_s;
    logic        wb_s;
    logic        ovf_chk_s;
    logic        legal_s;

    assign op_s            = instr_i[31:26];
    assign unused_rs_idx_s = instr_i[25:21];
    assign rt_idx_s        = instr_i[20:16];
    assign rd_idx_s        = instr_i[15:11];
    assign shamt_s         = instr_i[10:6];
    assign funct_s         = instr_i[5:0];
    assign imm_s           = instr_i[15:0];

    // Classify the instruction and pick aluc, operands and destination
    always_comb begin
        aluc_s    = ALU_ADDU;
        a_s       = rs_val_i;
        b_s       = rt_val_i;
        dest_s    = rd_idx_s;
        wb_s      = 1'b1;
        ovf_chk_s = 1'b0;
        legal_s   = 1'b1;
        case (op_s)
            OP_SPECIAL: begin
                case (funct_s)
                    FN_ADD:  begin aluc_s = ALU_ADD; ovf_chk_s = 1'b1; end
                    FN_ADDU: aluc_s = ALU_ADDU;
                    FN_SUB:  begin aluc_s = ALU_SUB; ovf_chk_s = 1'b1; end
                    FN_SUBU: aluc_s = ALU_SUBU;
                    FN_AND:  aluc_s = ALU_AND;
                    FN_OR:   aluc_s = ALU_OR;
                    FN_XOR:  aluc_s = ALU_XOR;
                    FN_NOR:  aluc_s = ALU_NOR;
                    FN_SLT:  aluc_s = ALU_SLT;
                    FN_SLTU: aluc_s = ALU_SLTU;
                    FN_SLL:  begin aluc_s = ALU_SLL; a_s = {27'd0, shamt_s}; end
                    FN_SRL:  begin aluc_s = ALU_SRL; a_s = {27'd0, shamt_s}; end
                    FN_SRA:  begin aluc_s = ALU_SRA; a_s = {27'd0, shamt_s}; end
                    FN_SLLV: begin aluc_s = ALU_SLL; a_s = {27'd0, rs_val_i[4:0]}; end
                    FN_SRLV: begin aluc_s = ALU_SRL; a_s = {27'd0, rs_val_i[4:0]}; end
                    FN_SRAV: begin aluc_s = ALU_SRA; a_s = {27'd0, rs_val_i[4:0]}; end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_ADDI: begin
                aluc_s = ALU_ADD; b_s = sext16(imm_s); dest_s = rt_idx_s; ovf_chk_s = 1'b1;
            end
            OP_ADDIU: begin aluc_s = ALU_ADDU; b_s = sext16(imm_s); dest_s = rt_idx_s; end
            OP_SLTI:  begin aluc_s = ALU_SLT;  b_s = sext16(imm_s); dest_s = rt_idx_s; end
            OP_SLTIU: begin aluc_s = ALU_SLTU; b_s = sext16(imm_s); dest_s = rt_idx_s; end
            OP_ANDI:  begin aluc_s = ALU_AND;  b_s = zext16(imm_s); dest_s = rt_idx_s; end
            OP_ORI:   begin aluc_s = ALU_OR;   b_s = zext16(imm_s); dest_s = rt_idx_s; end
            OP_XORI:  begin aluc_s = ALU_XOR;  b_s = zext16(imm_s); dest_s = rt_idx_s; end
            OP_LUI:   begin aluc_s = ALU_LUI;  b_s = zext16(imm_s); dest_s = rt_idx_s; end
            OP_BEQ, OP_BNE: begin
                aluc_s = ALU_SUBU; dest_s = 5'd0; wb_s = 1'b0;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Assemble the S1 record; unsupported codes collapse to a harmless no-op
    always_comb begin
        rec_o = '0;
        if (legal_s) begin
            rec_o.aluc    = aluc_s;
            rec_o.a       = a_s;
            rec_o.b       = b_s;
            rec_o.wr_addr = dest_s;
            rec_o.wr_en   = wb_s & (dest_s != 5'd0);
            rec_o.ovf_chk = ovf_chk_s & OVF_TRAP_EN;
            rec_o.illegal = 1'b0;
        end else begin
            rec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue pipeline in front of a combinational ALU.
// S1 holds the decoded instruction and drives the ALU; S2 captures the
// result, zero flag and write-back/exception information. Full backpressure.
// Build option: ALU_ISSUE_OVF_TRAP_EN turns overflow on add/sub/addi into an
// exception that suppresses write-back.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_wr_en,
    output logic [4:0]  out_wr_addr,
    output logic        out_ovf_exc,
    output logic        out_illegal
);

    s1_rec_t     dec_s;
    s1_rec_t     s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_result_q, s2_result_d;
    logic        s2_zero_q, s2_zero_d;
    logic        s2_wr_en_q, s2_wr_en_d;
    logic [4:0]  s2_wr_addr_q, s2_wr_addr_d;
    logic        s2_ovf_q, s2_ovf_d;
    logic        s2_illegal_q, s2_illegal_d;

    logic        s2_free_s;
    logic        s1_adv_s;
    logic        accept_s;
    logic        ovf_s;
    logic        unused_flags_s;

    alu_issue_dec u_dec (
        .instr_i  (in_instr),
        .rs_val_i (in_rs_val),
        .rt_val_i (in_rt_val),
        .rec_o    (dec_s)
    );

    // Carry and negative are stale across ops in this ALU and are ignored
    assign unused_flags_s = alu_carry ^ alu_negative;

    assign s2_free_s = ~s2_valid_q | out_ready;
    assign s1_adv_s  = s1_valid_q & s2_free_s;
    assign in_ready  = ~s1_valid_q | s2_free_s;
    assign accept_s  = in_valid & in_ready;
    assign ovf_s     = s1_q.ovf_chk & alu_overflow;

    // S1 next state: load on accept, drain on advance, otherwise hold
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (accept_s) begin
            s1_d       = dec_s;
            s1_valid_d = 1'b1;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: capture ALU outputs when S1 advances, empty on pop
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_zero_d    = s2_zero_q;
        s2_wr_en_d   = s2_wr_en_q;
        s2_wr_addr_d = s2_wr_addr_q;
        s2_ovf_d     = s2_ovf_q;
        s2_illegal_d = s2_illegal_q;
        if (s1_adv_s) begin
            s2_valid_d   = 1'b1;
            s2_result_d  = alu_r;
            s2_zero_d    = alu_zero;
            s2_wr_en_d   = s1_q.wr_en & ~ovf_s;
            s2_wr_addr_d = s1_q.wr_addr;
            s2_ovf_d     = ovf_s;
            s2_illegal_d = s1_q.illegal;
        end else if (s2_free_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // S1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    // S2 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            s2_result_q  <= 32'd0;
            s2_zero_q    <= 1'b0;
            s2_wr_en_q   <= 1'b0;
            s2_wr_addr_q <= 5'd0;
            s2_ovf_q     <= 1'b0;
            s2_illegal_q <= 1'b0;
        end else begin
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_zero_q    <= s2_zero_d;
            s2_wr_en_q   <= s2_wr_en_d;
            s2_wr_addr_q <= s2_wr_addr_d;
            s2_ovf_q     <= s2_ovf_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign alu_a       = s1_q.a;
    assign alu_b       = s1_q.b;
    assign alu_aluc    = s1_q.aluc;

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_zero    = s2_zero_q;
    assign out_wr_en   = s2_wr_en_q;
    assign out_wr_addr = s2_wr_addr_q;
    assign out_ovf_exc = s2_ovf_q;
    assign out_illegal = s2_illegal_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage for the CPU31 datapath that drives the combinational ALU from the initiator side. It accepts a decoded-ready instruction word plus register-file operands over a valid/ready handshake, generates the 4-bit `aluc`, selects the operands, presents them to the ALU, and captures the result and flags into an output register. The output register carries write-back and exception information downstream. The pipeline is two stages with full backpressure.

## Interface
- No parameters. Data width is fixed at 32 and the register index at 5.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction and operands are valid.
- `in_ready` out 1: the stage accepts the input this cycle.
- `in_instr` in 32: MIPS instruction word.
- `in_rs_val` in 32: value of rs.
- `in_rt_val` in 32: value of rt.
- `alu_a` out 32: operand a to the ALU.
- `alu_b` out 32: operand b to the ALU.
- `alu_aluc` out 4: ALU control code.
- `alu_r` in 32: ALU result.
- `alu_zero`, `alu_carry`, `alu_negative`, `alu_overflow` in 1 each: ALU flags.
- `out_valid` out 1: result register is valid.
- `out_ready` in 1: downstream accepts the result.
- `out_result` out 32: captured result.
- `out_zero` out 1: captured zero flag, used for beq/bne.
- `out_wr_en` out 1: write-back enable.
- `out_wr_addr` out 5: destination register.
- `out_ovf_exc` out 1: arithmetic overflow exception.
- `out_illegal` out 1: the opcode or funct is not in the supported set.

## Operation
- **S1 (decode register).** On `in_valid && in_ready`, S1 latches `aluc`, `a`, `b`, `wr_addr`, `wr_en`, `ovf_chk` and `illegal`.
- `alu_a`, `alu_b` and `alu_aluc` are driven directly from S1 and are combinational to the ALU.
- **R-type (op 0), funct to aluc:**
  - 0x20 add→0010, 0x21 addu→0000, 0x22 sub→0011, 0x23 subu→0001.
  - 0x24 and→0100, 0x25 or→0101, 0x26 xor→0110, 0x27 nor→0111.
  - 0x2A slt→1011, 0x2B sltu→1010.
  - 0x00 sll→1110, 0x02 srl→1101, 0x03 sra→1100.
  - 0x04 sllv→1110, 0x06 srlv→1101, 0x07 srav→1100.
  - Operands: a=rs, b=rt, dest=rd.
  - Fixed shifts: a={27'b0,shamt}. Variable shifts: a={27'b0,rs[4:0]}.
- **I-type, dest=rt, a=rs:**
  - 0x08 addi→0010 and 0x09 addiu→0000, b sign-extended.
  - 0x0A slti→1011 and 0x0B sltiu→1010, b sign-extended.
  - 0x0C andi→0100, 0x0D ori→0101, 0x0E xori→0110, b zero-extended.
  - 0x0F lui→1000, b={16'b0,imm}.
- **Branches.** 0x04 beq and 0x05 bne → 0001 with a=rs, b=rt, wr_en=0.
- **Overflow check.** `ovf_chk` is set only for add, sub and addi.
- **Zero destination.** If the destination is register 0, wr_en=0.
- **Unsupported codes.** Any other op or funct gives illegal=1, wr_en=0, aluc=0000, a=b=0.
- **S2 (result register).** On S1 advance, S2 captures `alu_r`, `alu_zero`, `wr_addr`, `illegal`, and `ovf = ovf_chk & alu_overflow`.
  - `out_wr_en = wr_en & ~ovf`.
  - `alu_carry` and `alu_negative` are not captured, because the ALU holds them stale across ops.

## Timing
- Reset values: all valid bits 0 and every output register 0. As a result, `alu_aluc`=0000, `alu_a`=`alu_b`=0, and `in_ready`=1 one cycle after reset release.
- Handshake control:
  - `s2_free = !out_valid || out_ready`.
  - `s1_adv = s1_valid && s2_free`.
  - `in_ready = !s1_valid || s2_free`. This is combinational; the only loop path is `out_ready`→`in_ready`.
- Latency is 2 cycles from input accept to `out_valid`. Throughput is 1 per cycle when `out_ready` is held high.
- Under a stall, S1 and S2 hold all fields, and the ALU inputs stay stable.
- **Simultaneous events:** accept, advance and output pop may all occur in the same cycle.
- **Reset mid-operation:** in-flight entries are discarded, and no output is produced for them.
- Outputs must not change while `out_valid && !out_ready`.

## Configuration
- Macro: `ALU_ISSUE_OVF_TRAP_EN`.
- **Defined:** overflow on add, sub or addi sets `out_ovf_exc=1` and forces `out_wr_en=0`.
- **Undefined:** `ovf_chk` is tied to 0, `out_ovf_exc` is constant 0, and the write proceeds with the wrapped result.

## Structure
- Package `alu_issue_pkg` holds:
  - the aluc constants (ALU_ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, LUI, SLT, SLTU, SRA, SLL, SRL);
  - the opcode and funct constants;
  - the S1 decoded-record typedef.
- Sub-module `alu_issue_dec` is the purely combinational decoder from instruction and operands to the S1 record.
- The top level holds S1, S2 and the handshake logic.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → `out_valid`=0 and all outputs 0. After release, `in_ready`=1 and no stale result appears.
- **addu then sra:**
  - addu $3,$1,$2 (rs=5, rt=7) → aluc=0000 on the next cycle; two cycles later result=12, wr_addr=3, wr_en=1.
  - sra $4,$2,4 (rt=0x80000000) → a=4, aluc=1100, result=0xF8000000.
- **addi overflow:** rs=0x7FFFFFFF, imm=1 → aluc=0010 and b=1.
  - With the macro defined: `out_ovf_exc`=1, `out_wr_en`=0.
  - Without it: `out_ovf_exc`=0, result=0x80000000, `out_wr_en`=1.
- **Immediate forms:**
  - ori imm=0x8000 → b=0x00008000.
  - lui imm=0x1234 → aluc=1000, result=0x12340000.
  - beq rs=rt=9 → `out_zero`=1, `out_wr_en`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with 3 back-to-back inputs.
  - Exactly 2 are accepted, then `in_ready`=0, with S2 outputs stable.
  - On release, results emerge in order with one per cycle.
- **Illegal and $0 destination:**
  - funct 0x3F → `out_illegal`=1, `out_wr_en`=0.
  - addu $0,… → `out_wr_en`=0.
